// File: rtl/decode_pkg.sv
// Shared encodings, FSM states and control bundle for the registered RV32I decode stage.
package decode_pkg;

  localparam logic [6:0] OP_RALU     = 7'b0110011;
  localparam logic [6:0] OP_IALU     = 7'b0010011;
  localparam logic [6:0] OP_ILOAD    = 7'b0000011;
  localparam logic [6:0] OP_SSTORE   = 7'b0100011;
  localparam logic [6:0] OP_ULOAD    = 7'b0110111;
  localparam logic [6:0] OP_UPC      = 7'b0010111;
  localparam logic [6:0] OP_IJUMP    = 7'b1100111;
  localparam logic [6:0] OP_SBBRANCH = 7'b1100011;
  localparam logic [6:0] OP_UJJUMP   = 7'b1101111;
  localparam logic [6:0] OP_ULADC    = 7'b0001011;
  localparam logic [6:0] OP_SSDAC    = 7'b0101011;

  localparam logic [2:0] WS_ALU = 3'b000;
  localparam logic [2:0] WS_RAM = 3'b001;
  localparam logic [2:0] WS_PC4 = 3'b010;
  localparam logic [2:0] WS_MUL = 3'b011;
  localparam logic [2:0] WS_ADC = 3'b100;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_JALR = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_JAL  = 2'b11;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_SH   = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD_WAIT,
    ST_LOAD_WB,
    ST_MUL_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic       regw;
    logic       ramr;
    logic       ramw;
    logic       sext;
    logic       mulen;
    logic       outputbool;
    logic [2:0] imm;
    logic [2:0] writesel;
    logic [1:0] pcsel;
  } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Pure instruction decode: raw instruction in, control bundle plus sequencing hints out.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit EN_M      = 1'b1,
  parameter bit EN_CUSTOM = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_load,
  output logic        is_mul
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_load = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_RALU: begin
        if (f7 == 7'b0000001) begin
          // the stage decides when regw fires; decode only tags the multiply
          if (EN_M) begin
            is_mul        = 1'b1;
            ctrl.mulen    = 1'b1;
            ctrl.writesel = WS_MUL;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          ctrl.aluop = {f3, f7[5]};
          ctrl.regw  = 1'b1;
        end
      end
      OP_IALU: begin
        ctrl.regw = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          ctrl.aluop = {f3, f7[5]};
          ctrl.imm   = IMM_SH;
          ctrl.sext  = ({f3, f7[5]} != 4'b1010);
        end else if (f3 == 3'b011) begin
          ctrl.aluop = 4'b0110;
          ctrl.imm   = IMM_I;
          ctrl.sext  = 1'b0;
        end else begin
          ctrl.aluop = {f3, 1'b0};
          ctrl.imm   = IMM_I;
          ctrl.sext  = 1'b1;
        end
      end
      OP_ILOAD: begin
        is_load   = 1'b1;
        ctrl.ramr = 1'b1;
        ctrl.imm  = IMM_I;
      end
      OP_SSTORE: begin
        ctrl.imm  = IMM_S;
        ctrl.ramw = 1'b1;
      end
      OP_ULOAD, OP_UPC: begin
        ctrl.imm  = IMM_U;
        ctrl.regw = 1'b1;
      end
      OP_IJUMP: begin
        ctrl.pcsel    = PC_JALR;
        ctrl.regw     = 1'b1;
        ctrl.writesel = WS_PC4;
      end
      OP_SBBRANCH: ctrl.pcsel = PC_BR;
      OP_UJJUMP: begin
        ctrl.pcsel    = PC_JAL;
        ctrl.regw     = 1'b1;
        ctrl.writesel = WS_PC4;
      end
      OP_ULADC: begin
        if (EN_CUSTOM) begin
          ctrl.regw     = 1'b1;
          ctrl.imm      = IMM_U;
          ctrl.writesel = WS_ADC;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SSDAC: begin
        if (EN_CUSTOM) ctrl.outputbool = 1'b1;
        else           illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-cycle-latency control bundle, with internal sequencing
// of multi-cycle loads and multiplies and a ready/valid accept handshake.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LOAD_LAT  = 1,
  parameter int MUL_LAT   = 2,
  parameter bit EN_M      = 1'b1,
  parameter bit EN_CUSTOM = 1'b1
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  input  logic            hold,
  output logic            ctrl_valid,
  output logic [3:0]      AluOp,
  output logic            regw,
  output logic            ramR,
  output logic            ramW,
  output logic            sext,
  output logic            mulEn,
  output logic            outputbool,
  output logic [2:0]      imm,
  output logic [2:0]      writesel,
  output logic [1:0]      pcsel,
  output logic            illegal,
  output logic            busy
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("decode_stage: only XLEN=32 is supported");
  end
  if (LOAD_LAT < 0 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("decode_stage: LOAD_LAT must be 0..7");
  end
  if (MUL_LAT < 1 || MUL_LAT > 7) begin : g_bad_mul_lat
    $error("decode_stage: MUL_LAT must be 1..7");
  end

  ctrl_t  dec_ctrl;
  logic   dec_ill, dec_ld, dec_mul;

  decode_comb #(
    .EN_M      (EN_M),
    .EN_CUSTOM (EN_CUSTOM)
  ) u_dec (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill),
    .is_load (dec_ld),
    .is_mul  (dec_mul)
  );

  state_t     state, nxt_st;
  logic [2:0] cnt, nxt_cnt;
  ctrl_t      ctrl_q, nxt_ctrl;
  logic       vld_q, nxt_vld;
  logic       ill_q, nxt_ill;
  logic       rdy_q, nxt_rdy;
  // an ISSUE cycle that opens a load or multi-cycle multiply sequence
  logic       pend_ld, nxt_pld;
  logic       pend_mul, nxt_pmul;
  logic       accept;

  assign instr_ready = rdy_q & ~hold;
  assign accept      = instr_valid & instr_ready;
  assign busy        = (state != ST_IDLE) && (state != ST_ISSUE);

  always_comb begin
    nxt_st   = state;
    nxt_cnt  = cnt;
    nxt_ctrl = '0;
    nxt_vld  = 1'b0;
    nxt_ill  = 1'b0;
    nxt_rdy  = 1'b1;
    nxt_pld  = 1'b0;
    nxt_pmul = 1'b0;
    if (state == ST_ISSUE && pend_ld) begin
      nxt_vld = 1'b1;
      if (LOAD_LAT == 0) begin
        nxt_st            = ST_LOAD_WB;
        nxt_ctrl.regw     = 1'b1;
        nxt_ctrl.writesel = WS_RAM;
      end else begin
        nxt_st  = ST_LOAD_WAIT;
        nxt_cnt = 3'(LOAD_LAT - 1);
        nxt_rdy = 1'b0;
      end
    end else if (state == ST_ISSUE && pend_mul) begin
      nxt_st            = ST_MUL_WAIT;
      nxt_vld           = 1'b1;
      nxt_ctrl.mulen    = 1'b1;
      nxt_ctrl.writesel = WS_MUL;
      nxt_cnt           = 3'(MUL_LAT - 2);
      nxt_ctrl.regw     = (MUL_LAT == 2);
      nxt_rdy           = (MUL_LAT == 2);
    end else if (state == ST_LOAD_WAIT) begin
      nxt_vld = 1'b1;
      if (cnt == 3'd0) begin
        nxt_st            = ST_LOAD_WB;
        nxt_ctrl.regw     = 1'b1;
        nxt_ctrl.writesel = WS_RAM;
      end else begin
        nxt_cnt = cnt - 3'd1;
        nxt_rdy = 1'b0;
      end
    end else if (state == ST_MUL_WAIT && cnt != 3'd0) begin
      // cnt counts remaining MUL_WAIT cycles after the current one
      nxt_vld           = 1'b1;
      nxt_ctrl.mulen    = 1'b1;
      nxt_ctrl.writesel = WS_MUL;
      nxt_cnt           = cnt - 3'd1;
      nxt_ctrl.regw     = (cnt == 3'd1);
      nxt_rdy           = (cnt == 3'd1);
    end else if (accept) begin
      nxt_st   = ST_ISSUE;
      nxt_vld  = 1'b1;
      nxt_ctrl = dec_ctrl;
      nxt_ill  = dec_ill;
      nxt_pld  = dec_ld;
      nxt_pmul = dec_mul && (MUL_LAT > 1);
      nxt_rdy  = !(dec_ld || nxt_pmul);
      if (dec_mul && MUL_LAT == 1) nxt_ctrl.regw = 1'b1;
    end else begin
      nxt_st = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      ctrl_q   <= '0;
      vld_q    <= 1'b0;
      ill_q    <= 1'b0;
      rdy_q    <= 1'b1;
      pend_ld  <= 1'b0;
      pend_mul <= 1'b0;
    end else if (!hold) begin
      state    <= nxt_st;
      cnt      <= nxt_cnt;
      ctrl_q   <= nxt_ctrl;
      vld_q    <= nxt_vld;
      ill_q    <= nxt_ill;
      rdy_q    <= nxt_rdy;
      pend_ld  <= nxt_pld;
      pend_mul <= nxt_pmul;
    end
  end

  assign ctrl_valid = vld_q;
  assign illegal    = ill_q;
  assign AluOp      = ctrl_q.aluop;
  assign regw       = ctrl_q.regw;
  assign ramR       = ctrl_q.ramr;
  assign ramW       = ctrl_q.ramw;
  assign sext       = ctrl_q.sext;
  assign mulEn      = ctrl_q.mulen;
  assign outputbool = ctrl_q.outputbool;
  assign imm        = ctrl_q.imm;
  assign writesel   = ctrl_q.writesel;
  assign pcsel      = ctrl_q.pcsel;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-cycle decodes plus hand sequences
// for loads, multiplies, illegal ops, async reset and hold.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] instr = 32'h0;

  logic       instr_ready, ctrl_valid, regw, ramR, ramW, sext, mulEn, outputbool, illegal, busy;
  logic [3:0] AluOp;
  logic [2:0] imm, writesel;
  logic [1:0] pcsel;

  logic       n_instr_ready, n_ctrl_valid, n_regw, n_ramR, n_ramW, n_sext, n_mulEn;
  logic       n_outputbool, n_illegal, n_busy;
  logic [3:0] n_AluOp;
  logic [2:0] n_imm, n_writesel;
  logic [1:0] n_pcsel;

  decode_stage #(.XLEN(32), .LOAD_LAT(1), .MUL_LAT(2), .EN_M(1'b1), .EN_CUSTOM(1'b1)) dut (
    .clock(clock), .nreset(nreset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .hold(hold), .ctrl_valid(ctrl_valid), .AluOp(AluOp),
    .regw(regw), .ramR(ramR), .ramW(ramW), .sext(sext), .mulEn(mulEn),
    .outputbool(outputbool), .imm(imm), .writesel(writesel), .pcsel(pcsel),
    .illegal(illegal), .busy(busy)
  );

  decode_stage #(.XLEN(32), .LOAD_LAT(1), .MUL_LAT(2), .EN_M(1'b0), .EN_CUSTOM(1'b0)) dut_nm (
    .clock(clock), .nreset(nreset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(n_instr_ready), .hold(hold), .ctrl_valid(n_ctrl_valid), .AluOp(n_AluOp),
    .regw(n_regw), .ramR(n_ramR), .ramW(n_ramW), .sext(n_sext), .mulEn(n_mulEn),
    .outputbool(n_outputbool), .imm(n_imm), .writesel(n_writesel), .pcsel(n_pcsel),
    .illegal(n_illegal), .busy(n_busy)
  );

  always #5 clock = ~clock;

  // {ctrl_valid, illegal, AluOp, regw, ramR, ramW, sext, mulEn, outputbool, imm, writesel, pcsel}
  logic [19:0] obs;
  assign obs = {ctrl_valid, illegal, AluOp, regw, ramR, ramW, sext, mulEn, outputbool,
                imm, writesel, pcsel};
  logic [19:0] rb;
  assign rb = {18'b0, instr_ready, busy};

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_LW  = 32'h0080A283;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic [5:0]  stb;   // regw, ramR, ramW, sext, mulEn, outputbool
    logic [2:0]  imm;
    logic [2:0]  ws;
    logic [1:0]  pc;
    logic        ill;
    logic        ill_nm;
  } vec_t;

  vec_t tv[16];

  function automatic logic [19:0] mk(input logic v, input logic ill, input logic [3:0] alu,
                                     input logic [5:0] stb, input logic [2:0] im,
                                     input logic [2:0] ws, input logic [1:0] pc);
    return {v, ill, alu, stb, im, ws, pc};
  endfunction

  function automatic vec_t vec(input logic [31:0] ins, input logic [3:0] alu,
                               input logic [5:0] stb, input logic [2:0] im, input logic [2:0] ws,
                               input logic [1:0] pc, input logic ill, input logic ill_nm);
    vec_t v;
    v.ins = ins; v.alu = alu; v.stb = stb; v.imm = im; v.ws = ws; v.pc = pc;
    v.ill = ill; v.ill_nm = ill_nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tv[0]  = vec(I_ADD,        4'b0000, 6'b100000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[1]  = vec(I_SUB,        4'b0001, 6'b100000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[2]  = vec(32'h4030D293, 4'b1011, 6'b100100, 3'b010, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[3]  = vec(32'h0030D293, 4'b1010, 6'b100000, 3'b010, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[4]  = vec(32'h00513093, 4'b0110, 6'b100000, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[5]  = vec(32'h00700093, 4'b0000, 6'b100100, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[6]  = vec(32'h0070F093, 4'b1110, 6'b100100, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[7]  = vec(32'h0010A423, 4'b0000, 6'b001000, 3'b011, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[8]  = vec(32'h0000007F, 4'b0000, 6'b000000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1);
    tv[9]  = vec(32'h000010B7, 4'b0000, 6'b100000, 3'b100, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[10] = vec(32'h00001097, 4'b0000, 6'b100000, 3'b100, 3'b000, 2'b00, 1'b0, 1'b0);
    tv[11] = vec(32'h000080E7, 4'b0000, 6'b100000, 3'b000, 3'b010, 2'b01, 1'b0, 1'b0);
    tv[12] = vec(32'h00208463, 4'b0000, 6'b000000, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0);
    tv[13] = vec(32'h008000EF, 4'b0000, 6'b100000, 3'b000, 3'b010, 2'b11, 1'b0, 1'b0);
    tv[14] = vec(32'h0000008B, 4'b0000, 6'b100000, 3'b100, 3'b100, 2'b00, 1'b0, 1'b1);
    tv[15] = vec(32'h0000002B, 4'b0000, 6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out", obs, 20'h0);
    chk("rst_rdy_busy", rb, {18'b0, 2'b10});
    chk("rst_nm_rdy", {19'b0, n_instr_ready}, 20'h1);
    nreset = 1'b1;

    // back-to-back single-cycle decodes
    for (int i = 0; i < 16; i++) begin
      instr = tv[i].ins;
      instr_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d", i), obs,
          mk(1'b1, tv[i].ill, tv[i].alu, tv[i].stb, tv[i].imm, tv[i].ws, tv[i].pc));
      chk($sformatf("vec%0d_rdy", i), rb, {18'b0, 2'b10});
      chk($sformatf("vec%0d_nm", i), {18'b0, n_ctrl_valid, n_illegal}, {18'b0, 1'b1, tv[i].ill_nm});
    end
    instr_valid = 1'b0;
    tick();
    chk("idle_after_table", obs, 20'h0);

    // multiply: two mulEn cycles, regw on the second; a waiting add lands right after
    instr = I_MUL; instr_valid = 1'b1;
    tick();
    chk("mul_issue", obs, mk(1'b1, 1'b0, 4'b0, 6'b000010, 3'b000, 3'b011, 2'b00));
    chk("mul_issue_rdy", rb, {18'b0, 2'b00});
    chk("mul_nm_illegal", {18'b0, n_ctrl_valid, n_illegal}, {18'b0, 2'b11});
    instr = I_ADD;
    tick();
    chk("mul_wb", obs, mk(1'b1, 1'b0, 4'b0, 6'b100010, 3'b000, 3'b011, 2'b00));
    chk("mul_wb_rdy", rb, {18'b0, 2'b11});
    tick();
    chk("mul_then_add", obs, mk(1'b1, 1'b0, 4'b0000, 6'b100000, 3'b000, 3'b000, 2'b00));
    chk("mul_then_add_rdy", rb, {18'b0, 2'b10});
    instr_valid = 1'b0;
    tick();
    chk("idle_after_mul", obs, 20'h0);

    // load with LOAD_LAT=1; a waiting sub is accepted on the LOAD_WB cycle
    instr = I_LW; instr_valid = 1'b1;
    tick();
    chk("ld_issue", obs, mk(1'b1, 1'b0, 4'b0, 6'b010000, 3'b001, 3'b000, 2'b00));
    chk("ld_issue_rdy", rb, {18'b0, 2'b00});
    instr = I_SUB;
    tick();
    chk("ld_wait", obs, mk(1'b1, 1'b0, 4'b0, 6'b000000, 3'b000, 3'b000, 2'b00));
    chk("ld_wait_rdy", rb, {18'b0, 2'b01});
    tick();
    chk("ld_wb", obs, mk(1'b1, 1'b0, 4'b0, 6'b100000, 3'b000, 3'b001, 2'b00));
    chk("ld_wb_rdy", rb, {18'b0, 2'b11});
    tick();
    chk("ld_then_sub", obs, mk(1'b1, 1'b0, 4'b0001, 6'b100000, 3'b000, 3'b000, 2'b00));
    instr_valid = 1'b0;
    tick();
    chk("idle_after_ld", obs, 20'h0);

    // async reset in LOAD_WAIT abandons the load
    instr = I_LW; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rld_wait", obs, mk(1'b1, 1'b0, 4'b0, 6'b000000, 3'b000, 3'b000, 2'b00));
    nreset = 1'b0;
    #2;
    chk("rld_async_out", obs, 20'h0);
    chk("rld_async_rdy", rb, {18'b0, 2'b10});
    nreset = 1'b1;
    tick();
    chk("rld_no_wb_1", obs, 20'h0);
    tick();
    chk("rld_no_wb_2", obs, 20'h0);

    // hold during ISSUE and MUL_WAIT stretches the multiply
    instr = I_MUL; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    hold = 1'b1;
    #1;
    chk("hold_rdy_low", rb, {18'b0, 2'b00});
    tick();
    chk("hold_issue_frz", obs, mk(1'b1, 1'b0, 4'b0, 6'b000010, 3'b000, 3'b011, 2'b00));
    hold = 1'b0;
    tick();
    chk("hold_mul_wb", obs, mk(1'b1, 1'b0, 4'b0, 6'b100010, 3'b000, 3'b011, 2'b00));
    hold = 1'b1;
    #1;
    chk("hold_wb_rdy", rb, {18'b0, 2'b01});
    repeat (2) begin
      tick();
      chk("hold_wb_frz", obs, mk(1'b1, 1'b0, 4'b0, 6'b100010, 3'b000, 3'b011, 2'b00));
    end
    hold = 1'b0;
    #1;
    chk("hold_release_rdy", rb, {18'b0, 2'b11});
    tick();
    chk("hold_end", obs, 20'h0);
    chk("hold_end_rdy", rb, {18'b0, 2'b10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational RV32I decoder. Sits between fetch and register-read/execute.
- Accepts one instruction per handshake and emits a one-cycle-latency registered control bundle.
- Sequences multi-cycle loads and M-extension multiplies internally; asserts ready low while busy.
- Flags illegal opcodes through a port instead of a simulation error.

Parameters:
- XLEN, 32, instruction/datapath width; only 32 is supported; elaboration error otherwise.
- LOAD_LAT, 1, RAM read wait cycles between the ramR cycle and the load writeback cycle (0..7).
- MUL_LAT, 2, total cycles mulEn is held before multiply writeback (1..7).
- EN_M, 1, when 0, funct7==1 on RALU decodes as illegal.
- EN_CUSTOM, 1, when 0, ULADC/SSDAC decode as illegal.

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- instr_valid  in  1  instr is valid this cycle
- instr  in  XLEN  raw instruction; opcode=[6:0], funct3=[14:12], funct7=[31:25]
- instr_ready  out  1  stage can accept an instruction this cycle
- hold  in  1  downstream stall; freezes all state and outputs
- ctrl_valid  out  1  control bundle valid this cycle
- AluOp  out  4  ALU operation
- regw, ramR, ramW, sext, mulEn, outputbool  out  1 each  control strobes
- imm  out  3  immediate format select
- writesel  out  3  writeback source: 000 ALU, 001 RAM, 010 PC+4, 011 MUL, 100 ADC
- pcsel  out  2  00 inc, 01 jalr, 10 branch, 11 jal
- illegal  out  1  undecodable instruction
- busy  out  1  FSM not in IDLE/ISSUE

Behaviour:
- Reset (nreset low, asynchronous):
  - FSM to IDLE.
  - All outputs 0 except instr_ready=1.
  - An in-flight load/multiply is abandoned; no writeback cycle is produced after release.
- hold=1: no state, counter or output register changes; instr_ready forced 0. hold dominates all other events.
- Accept: instr_valid & instr_ready at edge N → bundle on outputs during cycle N+1 with ctrl_valid=1. Without a new accept, ctrl_valid=0 and all strobes 0.
- FSM states: IDLE, ISSUE, LOAD_WAIT, LOAD_WB, MUL_WAIT.
  - IDLE/ISSUE: instr_ready=1. Back-to-back single-cycle instructions stay in ISSUE.
  - ILOAD accepted → ISSUE cycle: ramR=1, imm=001, AluOp=0000, regw=0.
  - Then LOAD_WAIT for LOAD_LAT cycles with all strobes 0; skipped when LOAD_LAT=0.
  - Then LOAD_WB for one cycle: regw=1, writesel=001.
  - A load occupies 2+LOAD_LAT output cycles; instr_ready=0 for all but the last. Next accept coincides with the LOAD_WB cycle.
  - RALU with funct7==1 (EN_M) → mulEn=1, writesel=011 held for MUL_LAT cycles (ISSUE then MUL_WAIT). regw=1 only on the final cycle. instr_ready=0 until that final cycle.
  - ctrl_valid=1 on every cycle of a multi-cycle sequence.
- Single-cycle decode table (all unlisted fields 0):
  - RALU: AluOp={funct3,funct7[5]}, regw=1, writesel=000.
  - IALU shifts (funct3 001/101): AluOp={funct3,funct7[5]}, imm=010; sext=0 iff AluOp==1010, else 1.
  - IALU sltiu (011): AluOp=0110, imm=001, sext=0.
  - IALU other: AluOp={funct3,0}, imm=001, sext=1.
  - All IALU: regw=1.
  - SSTORE: imm=011, ramW=1.
  - ULOAD/UPC: imm=100, regw=1.
  - IJUMP: pcsel=01, regw=1, writesel=010.
  - SBBRANCH: pcsel=10.
  - UJJUMP: pcsel=11, regw=1, writesel=010.
  - ULADC: regw=1, imm=100, writesel=100.
  - SSDAC: outputbool=1.
- Illegal opcode, or disabled extension: one cycle with ctrl_valid=1, illegal=1, all strobes 0; FSM returns to ISSUE.
- instr_valid while instr_ready=0 is ignored; upstream must hold the instruction.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (existing values: RALU 0110011, IALU 0010011, ILOAD 0000011, SSTORE 0100011, ULOAD 0110111, UPC 0010111, IJUMP 1100111, SBBRANCH 1100011, UJJUMP 1101111, ULADC 0001011, SSDAC 0101011)
  - writesel/pcsel/imm encodings
  - state enum
  - ctrl_t packed struct of the bundle
- One sub-module: decode_comb, a pure function from instr to {ctrl_t, illegal, is_load, is_mul}. decode_stage holds the FSM, counter and output register.

Test Plan:
- add x3,x1,x2 (0x002081B3) then sub (0x402081B3) back-to-back → two consecutive ctrl_valid cycles, AluOp 0000 then 0001, regw=1, writesel=000, instr_ready stays 1.
- srai x5,x1,3 (0x4030D293) → AluOp=1011, imm=010, sext=1; srli (0x0030D293) → AluOp=1010, sext=0.
- lw x5,8(x1) (0x0080A283), LOAD_LAT=1 → cycle N+1 ramR=1/regw=0, N+2 all strobes 0, N+3 regw=1/writesel=001; instr_ready low N+1..N+2.
- mul (0x022081B3), MUL_LAT=2 → mulEn=1 for 2 cycles, regw=1 only on the 2nd; with EN_M=0 → illegal=1 for 1 cycle.
- opcode 1111111 (0x0000007F) → illegal=1, ctrl_valid=1, all strobes 0; next instruction accepted immediately.
- nreset pulsed low during LOAD_WAIT, and hold=1 during MUL_WAIT → reset gives all outputs 0 immediately and no LOAD_WB; hold freezes mulEn and the counter and extends the sequence by the held cycles.
